// File: rtl/risc5_intc.sv
// Vectored, nesting interrupt controller for the RISC5 core: NCH prioritised channels, IO register window.
// Optional level-sensitive channels are enabled by defining INTC_LEVEL_EN.
module risc5_intc #(
  parameter int          NCH     = 8,
  parameter logic [21:0] VBASE   = 22'h000001,
  parameter int          VSTRIDE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] irq,
  input  logic           intAck,
  input  logic           intRet,
  output logic           intReq,
  output logic [21:0]    intVec,
  input  logic           iowr,
  input  logic           iord,
  input  logic [2:0]     ioadr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata
);

  localparam logic [2:0] ADR_ENABLE = 3'd0;
  localparam logic [2:0] ADR_PEND   = 3'd1;
  localparam logic [2:0] ADR_INSVC  = 3'd2;
  localparam logic [2:0] ADR_CTRL   = 3'd3;
  localparam logic [2:0] ADR_LEVEL  = 3'd4;

  logic [NCH-1:0] s1, s2, s3;
  logic [NCH-1:0] enable, pend, insvc;
  logic           gie;
  logic [3:0]     c_reg;

  logic [NCH-1:0] edge_ev, pe, pe_low, ins_low;
  logic [NCH-1:0] w1c, ack_mask, ret_mask, level_mask;
  logic [NCH-1:0] pend_nxt, insvc_nxt;
  logic [3:0]     cand_idx;
  logic           cand_found, preempt_ok, cand_valid, ack_fire;
  logic [21:0]    cand_vec;

  // iord carries no side effect: rdata is always live from ioadr.
  logic unused_bits;
  assign unused_bits = ^{iord, wdata};

  assign edge_ev = s2 & ~s3;

  // Lowest set bit as a one-hot; a smaller one-hot value means higher priority.
  assign pe         = pend & enable;
  assign pe_low     = pe & (~pe + NCH'(1));
  assign ins_low    = insvc & (~insvc + NCH'(1));
  assign cand_found = |pe;
  assign preempt_ok = (insvc == '0) || (pe_low < ins_low);
  assign cand_valid = cand_found && gie && preempt_ok;

  always_comb begin
    cand_idx = 4'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pe[i]) cand_idx = 4'(i);
    end
  end

  assign cand_vec = VBASE + 22'(VSTRIDE) * {18'd0, cand_idx};

  assign ack_fire = intAck & intReq;
  assign ack_mask = ack_fire ? (NCH'(1) << c_reg) : '0;
  assign ret_mask = intRet ? ins_low : '0;
  assign w1c      = (iowr && ioadr == ADR_PEND) ? wdata[NCH-1:0] : '0;

`ifdef INTC_LEVEL_EN
  logic [NCH-1:0] level;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (iowr && ioadr == ADR_LEVEL) begin
      level <= wdata[NCH-1:0];
    end
  end

  assign level_mask = level;
`else
  assign level_mask = '0;
`endif

  // Edge events beat clears; level channels simply follow the synchronised line.
  assign pend_nxt  = (((pend & ~w1c & ~ack_mask) | edge_ev) & ~level_mask) | (s2 & level_mask);
  // Return clears first, then the acknowledge sets.
  assign insvc_nxt = (insvc & ~ret_mask) | ack_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      enable <= '0;
      pend   <= '0;
      insvc  <= '0;
      gie    <= 1'b0;
      c_reg  <= 4'd0;
      intReq <= 1'b0;
      intVec <= 22'd0;
    end else begin
      s1    <= irq;
      s2    <= s1;
      s3    <= s2;
      pend  <= pend_nxt;
      insvc <= insvc_nxt;
      if (iowr && ioadr == ADR_ENABLE) enable <= wdata[NCH-1:0];
      if (iowr && ioadr == ADR_CTRL)   gie    <= wdata[0];
      // Suppress the request for one cycle after an acknowledge to avoid a double take.
      intReq <= cand_valid & ~ack_fire;
      if (cand_valid) begin
        intVec <= cand_vec;
        c_reg  <= cand_idx;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (ioadr)
      ADR_ENABLE: rdata = {{(32-NCH){1'b0}}, enable};
      ADR_PEND:   rdata = {{(32-NCH){1'b0}}, pend};
      ADR_INSVC:  rdata = {{(32-NCH){1'b0}}, insvc};
      ADR_CTRL:   rdata = {24'd0, cand_idx, 3'd0, gie};
`ifdef INTC_LEVEL_EN
      ADR_LEVEL:  rdata = {{(32-NCH){1'b0}}, level};
`endif
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_risc5_intc.sv
// Testbench for risc5_intc: directed scenarios plus randomized traffic against a behavioural model.
module tb_risc5_intc;

  localparam int          NCH     = 8;
  localparam logic [21:0] VBASE   = 22'h000001;
  localparam int          VSTRIDE = 2;

  logic        clk, rst, intAck, intRet, intReq, iowr, iord;
  logic [7:0]  irq;
  logic [21:0] intVec;
  logic [2:0]  ioadr;
  logic [31:0] wdata, rdata;

  int tests = 0;
  int fails = 0;

  risc5_intc #(.NCH(NCH), .VBASE(VBASE), .VSTRIDE(VSTRIDE)) dut (
    .clk(clk), .rst(rst), .irq(irq), .intAck(intAck), .intRet(intRet),
    .intReq(intReq), .intVec(intVec), .iowr(iowr), .iord(iord),
    .ioadr(ioadr), .wdata(wdata), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    iowr = 1'b1; ioadr = a; wdata = d;
    tick();
    iowr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    ioadr = a;
    #1;
    v = rdata;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq = m;
    tick();
    irq = 8'h00;
  endtask

  task automatic pulse_ack();
    intAck = 1'b1; tick(); intAck = 1'b0;
  endtask

  task automatic pulse_ret();
    intRet = 1'b1; tick(); intRet = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; tick_n(2); rst = 1'b0;
    tests++; if (intReq !== 1'b0) begin fails++; $display("FAIL reset_req got %0b exp 0", intReq); end
    tests++; if (intVec !== 22'd0) begin fails++; $display("FAIL reset_vec got %h exp 0", intVec); end
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), v);
      tests++; if (v !== 32'd0) begin fails++; $display("FAIL reset_reg%0d got %h exp 0", a, v); end
    end
  endtask

  task automatic test_single();
    logic [31:0] v;
    wr(3'd0, 32'hFF); wr(3'd3, 32'h1);
    pulse_irq(8'h08);
    tick();
    rd(3'd1, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL single_pend_early got %h exp 0", v); end
    tick();
    rd(3'd1, v);
    tests++; if (v !== 32'h08) begin fails++; $display("FAIL single_pend got %h exp 08", v); end
    tests++; if (intReq !== 1'b0) begin fails++; $display("FAIL single_req_early got %0b exp 0", intReq); end
    tick();
    tests++; if (intReq !== 1'b1) begin fails++; $display("FAIL single_req got %0b exp 1", intReq); end
    tests++; if (intVec !== 22'h000007) begin fails++; $display("FAIL single_vec got %h exp 000007", intVec); end
    pulse_ack();
    tests++; if (intReq !== 1'b0) begin fails++; $display("FAIL single_req_after_ack got %0b exp 0", intReq); end
    rd(3'd2, v);
    tests++; if (v !== 32'h08) begin fails++; $display("FAIL single_insvc got %h exp 08", v); end
    rd(3'd1, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL single_pend_cleared got %h exp 0", v); end
    pulse_ret();
    rd(3'd2, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL single_insvc_ret got %h exp 0", v); end
  endtask

  task automatic test_preempt_block();
    logic [31:0] v;
    pulse_irq(8'h24);
    tick_n(3);
    tests++; if (intReq !== 1'b1 || intVec !== 22'h000005) begin fails++; $display("FAIL prio_vec got req %0b vec %h exp 1 000005", intReq, intVec); end
    pulse_ack();
    rd(3'd2, v);
    tests++; if (v !== 32'h04) begin fails++; $display("FAIL prio_insvc got %h exp 04", v); end
    rd(3'd1, v);
    tests++; if (v !== 32'h20) begin fails++; $display("FAIL prio_pend got %h exp 20", v); end
    rd(3'd3, v);
    tests++; if (v !== 32'h51) begin fails++; $display("FAIL prio_ctrl got %h exp 51", v); end
    tick();
    tests++; if (intReq !== 1'b0) begin fails++; $display("FAIL prio_blocked got %0b exp 0", intReq); end
    pulse_ret();
    tick();
    tests++; if (intReq !== 1'b1 || intVec !== 22'h00000B) begin fails++; $display("FAIL prio_after_ret got req %0b vec %h exp 1 00000b", intReq, intVec); end
    pulse_ack();
    pulse_ret();
    rd(3'd2, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL prio_cleanup got %h exp 0", v); end
  endtask

  task automatic test_nesting();
    logic [31:0] v;
    pulse_irq(8'h10);
    tick_n(3);
    tests++; if (intReq !== 1'b1 || intVec !== 22'h000009) begin fails++; $display("FAIL nest_outer got req %0b vec %h exp 1 000009", intReq, intVec); end
    pulse_ack();
    rd(3'd2, v);
    tests++; if (v !== 32'h10) begin fails++; $display("FAIL nest_insvc1 got %h exp 10", v); end
    pulse_irq(8'h02);
    tick_n(3);
    tests++; if (intReq !== 1'b1 || intVec !== 22'h000003) begin fails++; $display("FAIL nest_inner got req %0b vec %h exp 1 000003", intReq, intVec); end
    pulse_ack();
    rd(3'd2, v);
    tests++; if (v !== 32'h12) begin fails++; $display("FAIL nest_insvc2 got %h exp 12", v); end
    pulse_ret();
    rd(3'd2, v);
    tests++; if (v !== 32'h10) begin fails++; $display("FAIL nest_ret1 got %h exp 10", v); end
    pulse_ret();
    rd(3'd2, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL nest_ret2 got %h exp 00", v); end
  endtask

  task automatic test_gie_w1c();
    logic [31:0] v;
    wr(3'd3, 32'h0);
    pulse_irq(8'h01);
    tick_n(2);
    rd(3'd1, v);
    tests++; if (v !== 32'h01) begin fails++; $display("FAIL gie_pend got %h exp 01", v); end
    tick();
    tests++; if (intReq !== 1'b0) begin fails++; $display("FAIL gie_req got %0b exp 0", intReq); end
    wr(3'd1, 32'h01);
    rd(3'd1, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL w1c_clear got %h exp 00", v); end
    pulse_irq(8'h01);
    tick();
    iowr = 1'b1; ioadr = 3'd1; wdata = 32'h01;
    tick();
    iowr = 1'b0;
    rd(3'd1, v);
    tests++; if (v !== 32'h01) begin fails++; $display("FAIL w1c_edge_wins got %h exp 01", v); end
    wr(3'd1, 32'h01);
    wr(3'd3, 32'h1);
    rd(3'd1, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL w1c_cleanup got %h exp 00", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    pulse_irq(8'h40);
    tick_n(3);
    tests++; if (intReq !== 1'b1 || intVec !== 22'h00000D) begin fails++; $display("FAIL b2b_vec got req %0b vec %h exp 1 00000d", intReq, intVec); end
    intAck = 1'b1; tick_n(2); intAck = 1'b0;
    rd(3'd2, v);
    tests++; if (v !== 32'h40) begin fails++; $display("FAIL b2b_insvc got %h exp 40", v); end
    rd(3'd1, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL b2b_pend got %h exp 00", v); end
    pulse_irq(8'h02);
    tick_n(3);
    tests++; if (intReq !== 1'b1 || intVec !== 22'h000003) begin fails++; $display("FAIL ackret_vec got req %0b vec %h exp 1 000003", intReq, intVec); end
    intAck = 1'b1; intRet = 1'b1; tick(); intAck = 1'b0; intRet = 1'b0;
    rd(3'd2, v);
    tests++; if (v !== 32'h02) begin fails++; $display("FAIL ackret_insvc got %h exp 02", v); end
    pulse_ret();
    rd(3'd2, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL ackret_cleanup got %h exp 00", v); end
  endtask

  task automatic test_enable_drop();
    logic [31:0] v;
    pulse_irq(8'h08);
    tick_n(3);
    tests++; if (intReq !== 1'b1) begin fails++; $display("FAIL endrop_req got %0b exp 1", intReq); end
    wr(3'd0, 32'hF7);
    tick();
    tests++; if (intReq !== 1'b0) begin fails++; $display("FAIL endrop_drop got %0b exp 0", intReq); end
    rd(3'd1, v);
    tests++; if (v !== 32'h08) begin fails++; $display("FAIL endrop_pend got %h exp 08", v); end
    wr(3'd1, 32'h08);
    wr(3'd0, 32'hFF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    pulse_irq(8'h04);
    tick_n(3);
    pulse_ack();
    pulse_irq(8'h80);
    tick_n(3);
    rd(3'd1, v);
    tests++; if (v !== 32'h80) begin fails++; $display("FAIL rstmid_pend got %h exp 80", v); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++; if (intReq !== 1'b0) begin fails++; $display("FAIL rstmid_req got %0b exp 0", intReq); end
    for (int a = 0; a < 4; a++) begin
      rd(3'(a), v);
      tests++; if (v !== 32'd0) begin fails++; $display("FAIL rstmid_reg%0d got %h exp 0", a, v); end
    end
  endtask

  task automatic test_level();
    logic [31:0] v;
    wr(3'd0, 32'hFF); wr(3'd3, 32'h1);
`ifdef INTC_LEVEL_EN
    wr(3'd4, 32'h01);
    rd(3'd4, v);
    tests++; if (v !== 32'h01) begin fails++; $display("FAIL level_reg got %h exp 01", v); end
    irq = 8'h01;
    tick_n(4);
    tests++; if (intReq !== 1'b1 || intVec !== 22'h000001) begin fails++; $display("FAIL level_req got req %0b vec %h exp 1 000001", intReq, intVec); end
    pulse_ack();
    rd(3'd1, v);
    tests++; if (v !== 32'h01) begin fails++; $display("FAIL level_ack_keeps got %h exp 01", v); end
    wr(3'd1, 32'h01);
    rd(3'd1, v);
    tests++; if (v !== 32'h01) begin fails++; $display("FAIL level_w1c_keeps got %h exp 01", v); end
    irq = 8'h00;
    tick_n(2);
    rd(3'd1, v);
    tests++; if (v !== 32'h01) begin fails++; $display("FAIL level_fall_early got %h exp 01", v); end
    tick();
    rd(3'd1, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL level_fall got %h exp 00", v); end
    pulse_ret();
    wr(3'd4, 32'h0);
`else
    wr(3'd4, 32'hFF);
    rd(3'd4, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL level_absent got %h exp 00", v); end
`endif
  endtask

  task automatic test_random();
    logic [7:0]  hist [3];
    logic [7:0]  m_pend, m_ins, m_en, n_pend, n_ins;
    logic        m_gie, m_req, ack, take;
    logic [21:0] m_vec;
    int          m_creg, mc, mi;
    logic [31:0] v;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    m_pend = 0; m_ins = 0; m_en = 0; m_gie = 0; m_req = 0; m_vec = 0; m_creg = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      irq    = 8'($urandom & $urandom & $urandom);
      intAck = ($urandom_range(0, 2) == 0);
      intRet = ($urandom_range(0, 7) == 0);
      iowr   = 1'b0;
      if (cyc == 0) begin iowr = 1'b1; ioadr = 3'd0; wdata = 32'hFF; end
      else if (cyc == 1) begin iowr = 1'b1; ioadr = 3'd3; wdata = 32'h1; end
      else if ($urandom_range(0, 9) == 0) begin
        iowr = 1'b1; ioadr = 3'($urandom_range(0, 3)); wdata = $urandom;
        if (ioadr == 3'd3) wdata[0] = ($urandom_range(0, 3) != 0);
        if (ioadr == 3'd0) wdata[7:0] = wdata[7:0] | 8'($urandom);
      end
      mc = -1; mi = -1;
      for (int i = 0; i < 8; i++) begin
        if (mc < 0 && m_pend[i] && m_en[i]) mc = i;
        if (mi < 0 && m_ins[i]) mi = i;
      end
      ack    = intAck && m_req;
      take   = (mc >= 0) && m_gie && (mi < 0 || mc < mi);
      n_pend = m_pend;
      if (iowr && ioadr == 3'd1) n_pend = n_pend & ~wdata[7:0];
      if (ack) n_pend[m_creg] = 1'b0;
      n_pend = n_pend | (hist[1] & ~hist[2]);
      n_ins = m_ins;
      if (intRet && mi >= 0) n_ins[mi] = 1'b0;
      if (ack) n_ins[m_creg] = 1'b1;
      m_req = take && !ack;
      if (take) begin m_vec = VBASE + 22'(mc * VSTRIDE); m_creg = mc; end
      if (iowr && ioadr == 3'd0) m_en = wdata[7:0];
      if (iowr && ioadr == 3'd3) m_gie = wdata[0];
      m_pend = n_pend; m_ins = n_ins;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq;
      tick();
      iowr = 1'b0; intAck = 1'b0; intRet = 1'b0;
      tests++; if (intReq !== m_req) begin fails++; $display("FAIL rnd_req cyc %0d got %0b exp %0b", cyc, intReq, m_req); end
      if (m_req) begin
        tests++; if (intVec !== m_vec) begin fails++; $display("FAIL rnd_vec cyc %0d got %h exp %h", cyc, intVec, m_vec); end
      end
      rd(3'd1, v);
      tests++; if (v !== {24'd0, m_pend}) begin fails++; $display("FAIL rnd_pend cyc %0d got %h exp %h", cyc, v, m_pend); end
      rd(3'd2, v);
      tests++; if (v !== {24'd0, m_ins}) begin fails++; $display("FAIL rnd_insvc cyc %0d got %h exp %h", cyc, v, m_ins); end
      mc = 0;
      for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) mc = i;
      rd(3'd3, v);
      tests++; if (v !== {24'd0, 4'(mc), 3'd0, m_gie}) begin fails++; $display("FAIL rnd_ctrl cyc %0d got %h exp idx %0d gie %0b", cyc, v, mc, m_gie); end
    end
  endtask

  initial begin
    rst = 1'b0; irq = 8'h00; intAck = 1'b0; intRet = 1'b0;
    iowr = 1'b0; iord = 1'b0; ioadr = 3'd0; wdata = 32'd0;
    tick();
    test_reset();
    test_single();
    test_preempt_block();
    test_nesting();
    test_gie_w1c();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_level();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
